// File: rtl/cmp_frame_minmax.sv
// Per-frame running max/min tracker for unsigned words with first-occurrence indices.
// One result record per frame is presented on a valid/ready handshake.
module cmp_frame_minmax #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_max,
  output logic [WIDTH-1:0] res_min,
  output logic [IDXW-1:0]  res_max_idx,
  output logic [IDXW-1:0]  res_min_idx,
  output logic [IDXW-1:0]  res_count,
  output logic             res_ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_e;

  localparam logic [IDXW-1:0] CNT_SAT = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_max_q, acc_max_d;
  logic [WIDTH-1:0] acc_min_q, acc_min_d;
  logic [IDXW-1:0]  acc_max_idx_q, acc_max_idx_d;
  logic [IDXW-1:0]  acc_min_idx_q, acc_min_idx_d;
  logic [IDXW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] res_max_q, res_max_d;
  logic [WIDTH-1:0] res_min_q, res_min_d;
  logic [IDXW-1:0]  res_max_idx_q, res_max_idx_d;
  logic [IDXW-1:0]  res_min_idx_q, res_min_idx_d;
  logic [IDXW-1:0]  res_count_q, res_count_d;
  logic             res_ovf_q, res_ovf_d;

  logic in_xfer;
  logic out_xfer;

  // Both handshake outputs decode the registered state only.
  assign in_ready  = (state_q != S_HOLD);
  assign res_valid = (state_q == S_HOLD);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = res_valid && res_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    acc_max_d     = acc_max_q;
    acc_min_d     = acc_min_q;
    acc_max_idx_d = acc_max_idx_q;
    acc_min_idx_d = acc_min_idx_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    res_max_d     = res_max_q;
    res_min_d     = res_min_q;
    res_max_idx_d = res_max_idx_q;
    res_min_idx_d = res_min_idx_q;
    res_count_d   = res_count_q;
    res_ovf_d     = res_ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          acc_max_d     = in_data;
          acc_min_d     = in_data;
          acc_max_idx_d = '0;
          acc_min_idx_d = '0;
          cnt_d         = IDXW'(1);
          ovf_d         = 1'b0;
          state_d       = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_xfer) begin
          // Strict compares keep the first occurrence; cnt_q is this word's index.
          if (in_data > acc_max_q) begin
            acc_max_d     = in_data;
            acc_max_idx_d = cnt_q;
          end
          if (in_data < acc_min_q) begin
            acc_min_d     = in_data;
            acc_min_idx_d = cnt_q;
          end
          if (cnt_q == CNT_SAT) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + IDXW'(1);
          if (in_last) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_xfer) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The visible record only changes on entry to HOLD.
    if ((state_q != S_HOLD) && (state_d == S_HOLD)) begin
      res_max_d     = acc_max_d;
      res_min_d     = acc_min_d;
      res_max_idx_d = acc_max_idx_d;
      res_min_idx_d = acc_min_idx_d;
      res_count_d   = cnt_d;
      res_ovf_d     = ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      acc_max_q     <= '0;
      acc_min_q     <= '0;
      acc_max_idx_q <= '0;
      acc_min_idx_q <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      res_max_q     <= '0;
      res_min_q     <= '0;
      res_max_idx_q <= '0;
      res_min_idx_q <= '0;
      res_count_q   <= '0;
      res_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_max_q     <= acc_max_d;
      acc_min_q     <= acc_min_d;
      acc_max_idx_q <= acc_max_idx_d;
      acc_min_idx_q <= acc_min_idx_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      res_max_q     <= res_max_d;
      res_min_q     <= res_min_d;
      res_max_idx_q <= res_max_idx_d;
      res_min_idx_q <= res_min_idx_d;
      res_count_q   <= res_count_d;
      res_ovf_q     <= res_ovf_d;
    end
  end

  assign res_max     = res_max_q;
  assign res_min     = res_min_q;
  assign res_max_idx = res_max_idx_q;
  assign res_min_idx = res_min_idx_q;
  assign res_count   = res_count_q;
  assign res_ovf     = res_ovf_q;

endmodule

// File: tb/tb_cmp_frame_minmax.sv
// Directed bench for cmp_frame_minmax: an IDXW=8 instance plus an IDXW=4 instance
// sharing the same stimulus so the 4-bit one exercises count saturation.
module tb_cmp_frame_minmax;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_last;
  logic          res_ready;

  logic          in_ready, res_valid, res_ovf;
  logic [W-1:0]  res_max, res_min;
  logic [7:0]    res_max_idx, res_min_idx, res_count;

  logic          in_ready4, res_valid4, res_ovf4;
  logic [W-1:0]  res_max4, res_min4;
  logic [3:0]    res_max_idx4, res_min_idx4, res_count4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cmp_frame_minmax #(.WIDTH(W), .IDXW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_max(res_max), .res_min(res_min),
    .res_max_idx(res_max_idx), .res_min_idx(res_min_idx),
    .res_count(res_count), .res_ovf(res_ovf)
  );

  cmp_frame_minmax #(.WIDTH(W), .IDXW(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready4),
    .res_valid(res_valid4), .res_ready(res_ready),
    .res_max(res_max4), .res_min(res_min4),
    .res_max_idx(res_max_idx4), .res_min_idx(res_min_idx4),
    .res_count(res_count4), .res_ovf(res_ovf4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] mx, input logic [7:0] mxi,
                           input logic [31:0] mn, input logic [7:0] mni,
                           input logic [7:0] cnt, input logic ov);
    chk({tag, "_valid"},   64'(res_valid),   64'(1));
    chk({tag, "_max"},     64'(res_max),     64'(mx));
    chk({tag, "_max_idx"}, 64'(res_max_idx), 64'(mxi));
    chk({tag, "_min"},     64'(res_min),     64'(mn));
    chk({tag, "_min_idx"}, 64'(res_min_idx), 64'(mni));
    chk({tag, "_count"},   64'(res_count),   64'(cnt));
    chk({tag, "_ovf"},     64'(res_ovf),     64'(ov));
  endtask

  // Drive one word on a falling edge; the next rising edge accepts it.
  task automatic push(input logic [31:0] d, input logic last);
    @(negedge clk);
    chk("push_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
  endtask

  // Idle cycles with junk on in_data/in_last that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic drain(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_drain_valid"}, 64'(res_valid), 64'(0));
    chk({tag, "_drain_ready"}, 64'(in_ready),  64'(1));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_in_ready",  64'(in_ready),    64'(1));
    chk("rst_res_valid", 64'(res_valid),   64'(0));
    chk("rst_res_max",   64'(res_max),     64'(0));
    chk("rst_res_min",   64'(res_min),     64'(0));
    chk("rst_max_idx",   64'(res_max_idx), 64'(0));
    chk("rst_min_idx",   64'(res_min_idx), 64'(0));
    chk("rst_count",     64'(res_count),   64'(0));
    chk("rst_ovf",       64'(res_ovf),     64'(0));
    rst_n = 1'b1;

    // Frame {5,9,2,9,2}: repeated extremes must keep the first index.
    push(32'd5, 1'b0);
    push(32'd9, 1'b0);
    push(32'd2, 1'b0);
    push(32'd9, 1'b0);
    push(32'd2, 1'b1);
    chk("f1_valid_before_last", 64'(res_valid), 64'(0));
    idle(1);
    check_res("f1", 32'd9, 8'd1, 32'd2, 8'd2, 8'd5, 1'b0);
    chk("f1_in_ready_hold", 64'(in_ready), 64'(0));
    drain("f1");

    // Single all-ones word, then 10 cycles of backpressure with a junk word offered.
    push(32'hFFFF_FFFF, 1'b1);
    idle(1);
    check_res("single", 32'hFFFF_FFFF, 8'd0, 32'hFFFF_FFFF, 8'd0, 8'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'd7;
      in_last  = 1'b1;
      chk("bp_in_ready",  64'(in_ready),  64'(0));
      chk("bp_res_valid", 64'(res_valid), 64'(1));
      chk("bp_res_max",   64'(res_max),   64'(32'hFFFF_FFFF));
      chk("bp_res_count", 64'(res_count), 64'(1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain("bp");

    // Frame {0,0}: zero is the smallest word, equal values never update.
    push(32'd0, 1'b0);
    push(32'd0, 1'b1);
    idle(1);
    check_res("zeros", 32'd0, 8'd0, 32'd0, 8'd0, 8'd2, 1'b0);
    drain("zeros");

    // Frame {3, gap x4, 7, gap x2, 1}; the old record must persist mid-frame.
    push(32'd3, 1'b0);
    idle(4);
    chk("bub_mid_valid", 64'(res_valid), 64'(0));
    chk("bub_mid_count", 64'(res_count), 64'(2));
    push(32'd7, 1'b0);
    idle(2);
    push(32'd1, 1'b1);
    idle(1);
    check_res("bubbles", 32'd7, 8'd1, 32'd1, 8'd2, 8'd3, 1'b0);
    drain("bubbles");

    // 20-word ramp 1..20: the IDXW=4 instance saturates at 15 and flags overflow.
    for (int v = 1; v <= 20; v++) push(32'(v), (v == 20));
    idle(1);
    check_res("ramp8", 32'd20, 8'd19, 32'd1, 8'd0, 8'd20, 1'b0);
    chk("ramp4_valid",   64'(res_valid4),   64'(1));
    chk("ramp4_count",   64'(res_count4),   64'(15));
    chk("ramp4_ovf",     64'(res_ovf4),     64'(1));
    chk("ramp4_max",     64'(res_max4),     64'(20));
    chk("ramp4_max_idx", 64'(res_max_idx4), 64'(15));
    chk("ramp4_min",     64'(res_min4),     64'(1));
    chk("ramp4_min_idx", 64'(res_min_idx4), 64'(0));
    drain("ramp");

    // Reset mid-frame: partial frame discarded, record cleared.
    push(32'd4, 1'b0);
    push(32'd6, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_valid", 64'(res_valid), 64'(0));
    chk("rst_mid_ready", 64'(in_ready),  64'(1));
    chk("rst_mid_count", 64'(res_count), 64'(0));
    chk("rst_mid_max",   64'(res_max),   64'(0));

    // Reset during HOLD: pending record discarded.
    push(32'd8, 1'b1);
    idle(1);
    chk("pre_hold_valid", 64'(res_valid), 64'(1));
    chk("pre_hold_max",   64'(res_max),   64'(8));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_hold_valid", 64'(res_valid), 64'(0));
    chk("rst_hold_ready", 64'(in_ready),  64'(1));
    chk("rst_hold_max",   64'(res_max),   64'(0));

    // Clean frame {4,6} after the resets.
    push(32'd4, 1'b0);
    push(32'd6, 1'b1);
    idle(1);
    check_res("post_rst", 32'd6, 8'd1, 32'd4, 8'd0, 8'd2, 1'b0);
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmp_frame_minmax.md
Name: cmp_frame_minmax

Overview:
- Sequential consumer of 32-bit unsigned magnitude-compare results.
- Accepts a framed stream of words and, per frame, tracks the running maximum and minimum and the index of each.
- Presents one result record per frame through a valid/ready handshake.
- Sits downstream of the cascaded magnitude comparator. Each cycle it compares the incoming word against the held max and the held min, using unsigned strictly-greater and strictly-less decisions.

Parameters:
- WIDTH, 32, data word width in bits (unsigned).
- IDXW, 8, width of index and count fields.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  WIDTH  word to compare.
- in_valid  input  1  in_data/in_last valid.
- in_last  input  1  marks final word of frame.
- in_ready  output  1  block can accept a word this cycle.
- res_valid  output  1  result record valid.
- res_ready  input  1  downstream accepts record.
- res_max  output  WIDTH  largest word in frame.
- res_min  output  WIDTH  smallest word in frame.
- res_max_idx  output  IDXW  index of first occurrence of max.
- res_min_idx  output  IDXW  index of first occurrence of min.
- res_count  output  IDXW  number of words in frame, saturating.
- res_ovf  output  1  frame exceeded 2^IDXW-1 words.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid and in_ready are both high on a clock edge.
  - Output transfer occurs when res_valid and res_ready are both high on a clock edge.
- Reset: when rst_n is low on a clock edge, the following are cleared:
  - state to IDLE;
  - in_ready to 1, res_valid to 0;
  - res_max, res_min, res_max_idx, res_min_idx, res_count and res_ovf to 0;
  - internal index counter to 0.
  - Reset mid-frame or mid-hold discards all partial or pending results; nothing is emitted.
- States:
  - IDLE: in_ready=1. On an input transfer:
    - load max=min=in_data, max_idx=min_idx=0, cnt=1, ovf=0;
    - if in_last, go to HOLD; otherwise go to ACCUM.
  - ACCUM: in_ready=1. On an input transfer with word index i=cnt:
    - if in_data > max, then max=in_data and max_idx=i;
    - if in_data < min, then min=in_data and min_idx=i;
    - equal values never update, so the first occurrence wins;
    - both max and min may update in the same cycle only when neither held value is stale, which cannot occur; at most one updates per word after the first;
    - cnt increments;
    - if in_last, go to HOLD.
  - HOLD: in_ready=0, res_valid=1, result registers stable.
    - On an output transfer, go to IDLE with res_valid=0 in the next cycle.
    - While res_ready is low, all res_* outputs hold unchanged.
- Latency: res_valid rises in the cycle immediately after the edge that accepted the in_last word.
  - Example: last word accepted at edge N, res_valid is high from edge N onward.
  - Minimum frame-to-frame gap is one HOLD cycle with res_ready=1.
- Result registers update only at the transition into HOLD. Between frames they retain the last record; only res_valid qualifies them.
- Single-word frame (in_last on the first word): max=min=word, both indices 0, count=1.
- Saturation:
  - cnt saturates at 2^IDXW-1. Once a word is accepted with cnt already saturated, ovf is set and stays set for the frame.
  - Words in an overflowed frame are still compared.
  - An index recorded after saturation takes the value 2^IDXW-1.
- in_valid low in ACCUM stalls with no state change; frames may have arbitrary bubbles.
- in_data and in_last are ignored when in_valid is low.
- Comparisons are full WIDTH unsigned; the all-ones word is the largest and 0 is the smallest.
- No combinational path from res_ready to in_ready beyond the state decode. in_ready is a function of the registered state only.

Test Plan:
- Reset then frame {5,9,2,9,2} (last on the 5th word) -> res_max=9, max_idx=1, res_min=2, min_idx=2, count=5, ovf=0; res_valid is high the cycle after the last word.
- Single-word frame {0xFFFFFFFF} -> max=min=0xFFFFFFFF, both indices 0, count=1; then frame {0,0} -> max=min=0, indices 0, count=2.
- Backpressure: hold res_ready=0 for 10 cycles after a frame -> in_ready=0 and res_* stable throughout; res_ready=1 -> res_valid drops next cycle and in_ready returns to 1.
- Input bubbles: frame {3, gap x4, 7, gap x2, 1} -> max=7 idx=1, min=1 idx=2, count=3.
- Overflow with IDXW=4: 20-word frame, increasing ramp 1..20 -> count=15, ovf=1, max=20, max_idx=15, min=1, min_idx=0.
- Reset: assert rst_n=0 mid-frame and also during HOLD -> no res_valid pulse; the next clean frame {4,6} gives max=6 idx=1, min=4 idx=0, count=2.
